// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock/tick divider.
//   MIN_DIV        : smallest divisor a reload may request
//   chan_state_e   : per-channel FSM encoding (StIdle / StRun)
//   chan_idx_width : channel-index width, never narrower than one bit
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } chan_state_e;

  function automatic int unsigned chan_idx_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: FSM, cycle counter, current and pending divisor/high-time
// registers, registered divided clock and period-start tick.
// Ports:
//   clk_i       system clock (posedge)
//   rst_i       synchronous active-high reset
//   en_i        run enable
//   load_i      one-cycle strobe: store load_div_i/load_hi_i as a pending reload
//   load_div_i  validated divisor
//   load_hi_i   validated, already-substituted high time
//   clk_out_o   divided clock, registered
//   tick_o      one-cycle pulse at each period start, registered
//   pending_o   a reload is stored and not yet applied
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_div_i,
  input  logic [W-1:0] load_hi_i,
  output logic         clk_out_o,
  output logic         tick_o,
  output logic         pending_o
);

  localparam logic [W-1:0] DefDiv = W'(DEFAULT_DIV);
  localparam logic [W-1:0] DefHi  = DefDiv >> 1;
  localparam logic [W-1:0] One    = W'(1);

  chan_state_e  state_q;
  logic [W-1:0] cnt_q, div_cur_q, hi_cur_q, pend_div_q, pend_hi_q;
  logic         pend_q, clk_out_q, tick_q;

  logic         wrap;
  logic         swap;
  logic [W-1:0] cnt_next, hi_next;

  always_comb begin
    wrap     = (cnt_q == (div_cur_q - One));
    swap     = wrap && pend_q;
    cnt_next = wrap ? '0 : (cnt_q + One);
    // The period that starts at a wrap already uses the pending high time.
    hi_next  = swap ? pend_hi_q : hi_cur_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_cur_q  <= DefDiv;
      hi_cur_q   <= DefHi;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      pend_hi_q  <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      // Only ever strobed while nothing is pending, so it never races an apply.
      if (load_i) begin
        pend_q     <= 1'b1;
        pend_div_q <= load_div_i;
        pend_hi_q  <= load_hi_i;
      end
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            div_cur_q <= pend_div_q;
            hi_cur_q  <= pend_hi_q;
            pend_q    <= 1'b0;
          end
          cnt_q <= '0;
          if (en_i) begin
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
            state_q   <= StRun;
          end else begin
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
          end
        end
        StRun: begin
          if (!en_i) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cnt_q     <= cnt_next;
            clk_out_q <= (cnt_next < hi_next);
            tick_q    <= (cnt_next == '0);
            if (swap) begin
              div_cur_q <= pend_div_q;
              hi_cur_q  <= pend_hi_q;
              pend_q    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock/tick divider. NCH independent channels each produce a
// registered divided clock and a period-start tick; divisor and high time are
// reloaded through a valid/ready port and take effect at the next period boundary.
// Ports:
//   clk         system clock (posedge)
//   rst         synchronous active-high reset
//   en          per-channel run enable
//   load_valid  reload request
//   load_ready  combinational: target channel has no reload pending
//   load_ch     target channel
//   load_div    new divisor (period in clk cycles)
//   load_hi     new high time; 0 selects load_div/2
//   load_err    one-cycle pulse: last accepted reload was rejected
//   clk_out     divided clocks
//   tick        period-start pulses
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NCH         = 4,
  parameter  int unsigned W           = 32,
  parameter  int unsigned DEFAULT_DIV = 100_000_000,
  localparam int unsigned CW          = chan_idx_width(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [CW-1:0]  load_ch,
  input  logic [W-1:0]   load_div,
  input  logic [W-1:0]   load_hi,
  output logic           load_err,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  logic [NCH-1:0] pending;
  logic           accept, bad, accept_ok;
  logic [W-1:0]   hi_eff;
  logic           load_err_q;

  // A channel index past NCH reads as ready so the request is accepted and
  // then rejected, giving the requester an explicit error pulse.
  always_comb begin
    load_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (load_ch == CW'(i)) load_ready = ~pending[i];
    end
  end

  always_comb begin
    accept    = load_valid && load_ready;
    bad       = (load_div < W'(MIN_DIV)) || (load_hi >= load_div) || (32'(load_ch) >= NCH);
    accept_ok = accept && !bad;
    hi_eff    = (load_hi == '0) ? (load_div >> 1) : load_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= accept && bad;
    end
  end

  assign load_err = load_err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic strobe;
    assign strobe = accept_ok && (load_ch == CW'(g));

    clk_div_chan #(
      .W          (W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en[g]),
      .load_i    (strobe),
      .load_div_i(load_div),
      .load_hi_i (hi_eff),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g]),
      .pending_o (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Four-channel instance
  logic [3:0]  en   = '0;
  logic        lv   = 1'b0;
  logic        lready;
  logic [1:0]  lch  = '0;
  logic [15:0] ldiv = '0;
  logic [15:0] lhi  = '0;
  logic        lerr;
  logic [3:0]  clk_out, tick;

  // Three-channel instance, used for the out-of-range channel index
  logic [2:0]  en3   = '0;
  logic        lv3   = 1'b0;
  logic        lready3;
  logic [1:0]  lch3  = '0;
  logic [15:0] ldiv3 = '0;
  logic [15:0] lhi3  = '0;
  logic        lerr3;
  logic [2:0]  co3, tk3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_div_multi #(.NCH(4), .W(16), .DEFAULT_DIV(10)) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv), .load_ready(lready), .load_ch(lch),
    .load_div(ldiv), .load_hi(lhi), .load_err(lerr), .clk_out(clk_out), .tick(tick)
  );

  clk_div_multi #(.NCH(3), .W(16), .DEFAULT_DIV(10)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .load_valid(lv3), .load_ready(lready3), .load_ch(lch3),
    .load_div(ldiv3), .load_hi(lhi3), .load_err(lerr3), .clk_out(co3), .tick(tk3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = '0;
    lv  = 1'b0;
    en3 = '0;
    lv3 = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (clk_out !== 4'b0) begin errors++; $display("FAIL reset_clk got=%b exp=0000", clk_out); end
    checks++; if (tick !== 4'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0000", tick); end
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", lerr); end
    checks++; if (lready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", lready); end
    checks++; if (co3 !== 3'b0) begin errors++; $display("FAIL reset_clk3 got=%b exp=000", co3); end
  endtask

  task automatic test_default();
    logic [3:0] ec, et;
    do_reset();
    en[0] = 1'b1;
    step();
    for (int k = 0; k < 25; k++) begin
      ec = ((k % 10) < 5) ? 4'b0001 : 4'b0000;
      et = ((k % 10) == 0) ? 4'b0001 : 4'b0000;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL default_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, et); end
      step();
    end
  endtask

  task automatic test_reload();
    logic [3:0] ec, et;
    logic       er;
    do_reset();
    en[1] = 1'b1;
    lch   = 2'd1;
    step();
    for (int k = 0; k < 22; k++) begin
      if (k < 10) begin
        ec = (k < 5) ? 4'b0010 : 4'b0000;
        et = (k == 0) ? 4'b0010 : 4'b0000;
      end else begin
        ec = (((k - 10) % 4) == 0) ? 4'b0010 : 4'b0000;
        et = ec;
      end
      er = (k >= 4 && k <= 9) ? 1'b0 : 1'b1;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL reload_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL reload_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (lready !== er) begin errors++; $display("FAIL reload_ready k=%0d got=%b exp=%b", k, lready, er); end
      if (k == 3) begin
        lv = 1'b1; ldiv = 16'd4; lhi = 16'd1;
      end else begin
        lv = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reject();
    logic [3:0] ec, et;
    logic       ee, er;
    do_reset();
    en[0] = 1'b1;
    lch   = 2'd0;
    step();
    for (int k = 0; k < 26; k++) begin
      if (k < 10) begin
        ec = (k < 5) ? 4'b0001 : 4'b0000;
        et = (k == 0) ? 4'b0001 : 4'b0000;
      end else begin
        ec = (((k - 10) % 7) < 3) ? 4'b0001 : 4'b0000;
        et = (((k - 10) % 7) == 0) ? 4'b0001 : 4'b0000;
      end
      ee = (k == 2 || k == 4);
      er = (k >= 6 && k <= 9) ? 1'b0 : 1'b1;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL reject_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL reject_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (lerr !== ee) begin errors++; $display("FAIL reject_err k=%0d got=%b exp=%b", k, lerr, ee); end
      checks++; if (lready !== er) begin errors++; $display("FAIL reject_ready k=%0d got=%b exp=%b", k, lready, er); end
      case (k)
        1:       begin lv = 1'b1; ldiv = 16'd1; lhi = 16'd0; end
        3:       begin lv = 1'b1; ldiv = 16'd5; lhi = 16'd5; end
        5:       begin lv = 1'b1; ldiv = 16'd7; lhi = 16'd0; end
        default: lv = 1'b0;
      endcase
      step();
    end
    // Channel index equal to NCH on the three-channel instance
    lch3 = 2'd3; ldiv3 = 16'd7; lhi3 = 16'd0; lv3 = 1'b1;
    step();
    lv3 = 1'b0;
    checks++; if (lerr3 !== 1'b1) begin errors++; $display("FAIL reject_ch_err got=%b exp=1", lerr3); end
    step();
    checks++; if (lerr3 !== 1'b0) begin errors++; $display("FAIL reject_ch_err_clear got=%b exp=0", lerr3); end
    checks++; if (co3 !== 3'b0) begin errors++; $display("FAIL reject_ch_clk got=%b exp=000", co3); end
    lch3 = 2'd2;
    #1;
    checks++; if (lready3 !== 1'b1) begin errors++; $display("FAIL reject_ch_ready got=%b exp=1", lready3); end
  endtask

  task automatic test_stop_restart();
    logic [3:0] ec, et;
    do_reset();
    en[2] = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      ec = 4'b0100;
      et = (k == 0) ? 4'b0100 : 4'b0000;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL stop_pre_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL stop_pre_tick k=%0d got=%b exp=%b", k, tick, et); end
      if (k < 3) step();
    end
    en[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (clk_out !== 4'b0) begin errors++; $display("FAIL stop_clk k=%0d got=%b exp=0000", k, clk_out); end
      checks++; if (tick !== 4'b0) begin errors++; $display("FAIL stop_tick k=%0d got=%b exp=0000", k, tick); end
    end
    en[2] = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      ec = ((k % 10) < 5) ? 4'b0100 : 4'b0000;
      et = ((k % 10) == 0) ? 4'b0100 : 4'b0000;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL restart_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL restart_tick k=%0d got=%b exp=%b", k, tick, et); end
      step();
    end
  endtask

  task automatic test_reset_pending();
    logic [3:0] ec, et;
    do_reset();
    en[3] = 1'b1;
    lch   = 2'd3;
    step();
    step();
    lv = 1'b1; ldiv = 16'd4; lhi = 16'd2;
    step();
    lv = 1'b0;
    checks++; if (lready !== 1'b0) begin errors++; $display("FAIL rstpend_ready_low got=%b exp=0", lready); end
    rst = 1'b1;
    step();
    checks++; if (clk_out !== 4'b0) begin errors++; $display("FAIL rstpend_clk got=%b exp=0000", clk_out); end
    checks++; if (tick !== 4'b0) begin errors++; $display("FAIL rstpend_tick got=%b exp=0000", tick); end
    checks++; if (lready !== 1'b1) begin errors++; $display("FAIL rstpend_ready got=%b exp=1", lready); end
    rst = 1'b0;
    step();
    for (int k = 0; k < 22; k++) begin
      ec = ((k % 10) < 5) ? 4'b1000 : 4'b0000;
      et = ((k % 10) == 0) ? 4'b1000 : 4'b0000;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL rstpend_run_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL rstpend_run_tick k=%0d got=%b exp=%b", k, tick, et); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int         d [4];
    int         dd, hh, base;
    logic [3:0] ec, et;
    logic       er;
    d = '{2, 3, 4, 5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lv = 1'b1; lch = 2'(i); ldiv = 16'(d[i]); lhi = 16'd0;
      step();
    end
    lv = 1'b0;
    step();
    lch = 2'd2;
    en  = 4'hf;
    step();
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 2 && k >= 12) begin
          dd = 6; hh = 1; base = 12;
        end else begin
          dd = d[i]; hh = d[i] / 2; base = 0;
        end
        ec[i] = (((k - base) % dd) < hh);
        et[i] = (((k - base) % dd) == 0);
      end
      er = (k >= 8 && k <= 11) ? 1'b0 : 1'b1;
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL multi_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
      checks++; if (tick !== et) begin errors++; $display("FAIL multi_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (lready !== er) begin errors++; $display("FAIL multi_ready k=%0d got=%b exp=%b", k, lready, er); end
      if (k == 7) begin
        lv = 1'b1; ldiv = 16'd6; lhi = 16'd1;
      end else begin
        lv = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_reload();
    test_reject();
    test_stop_restart();
    test_reset_pending();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock/tick divider. Each of NCH channels counts system-clock cycles and drives a registered divided clock with programmable period and high time, plus a one-cycle tick at each period start. Divisor and high time are reloadable at run time through a valid/ready port and take effect glitch-free at the next period boundary. Sits beside the system clock as the common source of slow clocks and enables such as 1 Hz display refresh and stepping.

Parameters:
NCH, 4, number of independent channels (>=1)
W, 32, width of counters, divisor and high-time values
DEFAULT_DIV, 100_000_000, reset divisor for every channel (>=2); reset high time is DEFAULT_DIV/2
CW, max(1,$clog2(NCH)), channel-index width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
en  in  NCH  per-channel run enable
load_valid  in  1  reload request
load_ready  out  1  combinational: ~pending[load_ch]
load_ch  in  CW  target channel of reload
load_div  in  W  new divisor (period in clk cycles)
load_hi  in  W  new high time in clk cycles; 0 = use load_div/2
load_err  out  1  one-cycle pulse: last accepted reload rejected
clk_out  out  NCH  divided clocks, registered
tick  out  NCH  one-cycle pulse at each period start, registered

Behaviour:
- Reset (rst=1 at posedge): per channel cnt=0, div_cur=DEFAULT_DIV, hi_cur=DEFAULT_DIV/2, pending=0, state IDLE; clk_out=0, tick=0, load_err=0. rst overrides all other inputs, and a pending reload is discarded.
- Per-channel FSM, states IDLE and RUN.
- IDLE, en=0: cnt=0, clk_out=0, tick=0. If pending=1, apply it (div_cur/hi_cur <= pending values, pending<=0).
- IDLE, en=1 at the edge: cnt<=0, clk_out<=1, tick<=1, go RUN. Apply any pending values first so that the first period uses them.
- RUN, en=1: cnt_next = (cnt==div_cur-1) ? 0 : cnt+1. clk_out <= (cnt_next < hi_cur). tick <= (cnt_next==0).
- RUN, wrap (cnt==div_cur-1) with pending=1: the new values load at that edge and govern the period starting with cnt_next=0. Compare against the new hi for clk_out.
- RUN, en=0: go IDLE next edge with cnt<=0, clk_out<=0, tick<=0. The stop is immediate and a truncated high phase is allowed.
- Resulting waveform for div=D, hi=H: clk_out high H cycles, then low D-H cycles; tick coincides with the first high cycle.
- Reload handshake: accepted when load_valid && load_ready at the edge.
  - Validation on acceptance: div<2, or hi>=div, or load_ch>=NCH → rejected. Nothing changes and load_err=1 on the next cycle.
  - Valid request: pending[load_ch]<=1 and values stored, with hi=0 replaced by div>>1.
  - Only one pending reload per channel. load_ready stays low for that channel until the reload is applied.
- Acceptance on the same edge as a wrap: the reload does not apply at that wrap. It applies at the next wrap, or the next IDLE cycle.
- Channels are fully independent. Simultaneous wraps, enables and a reload to another channel do not interact.
- Arithmetic is unsigned W-bit. cnt never exceeds div_cur-1, and no overflow is possible because div_cur <= 2^W-1.

Decomposition:
- Shared package/include clk_div_pkg: localparams MIN_DIV=2, ST_IDLE/ST_RUN encodings, and the CW derivation function.
- Sub-module clk_div_chan: one channel holding FSM, counter, current/pending registers and clk_out/tick. It has a local load strobe and a pending output.
- Top clk_div_multi: generate loop of NCH clk_div_chan instances, load_ch decode, validation, load_ready mux and load_err register.

Test Plan:
- DEFAULT_DIV=10, rst then en[0]=1 → starting the edge after en is sampled, clk_out[0] is 5 high / 5 low repeating; tick[0] pulses every 10 cycles, aligned with each rising edge.
- ch1 running at div 10; at cnt=3 load div=4, hi=1 → load_ready low; current period completes 10 cycles; then clk_out 1 high / 3 low; load_ready high again the cycle after the wrap.
- Rejected reloads: div=1; div=5 hi=5; load_ch=NCH (NCH=3) → load_err pulses exactly one cycle each and waveform is unchanged. Accepted reload div=7 hi=0 → 3 high / 4 low.
- Deassert en[2] during the high phase → clk_out[2]=0 next cycle and no tick. Reassert en[2] → immediate tick and a full-length high phase.
- rst pulse mid-run with a reload pending → all outputs 0; after release and enable, period is DEFAULT_DIV and the pending values are never applied.
- Four channels at div 2/3/4/5 with a reload to ch2 accepted on ch2's wrap edge → ch2 switches one period later; ch0, ch1 and ch3 are undisturbed, including div=2 (1 high / 1 low).
